ps2_host_tx: RTL and testbench
==============================

# ps2_host_tx

Host-to-device PS/2 transmitter, the send side for the existing keyboard receiver. It sends one command byte to the keyboard, such as set-LEDs 0xED or reset 0xFF. It drives the shared PS2_CLK/PS2_DAT lines as open-drain enables and reports the device acknowledge. The top level turns each enable into a tri-state pin: drive 0 when the enable is high, otherwise Z. While `busy` is high, the top level must hold the receiver inactive.

## Interface
- INHIBIT_CYCLES, 5000: clock hold-low time in clk cycles (100 us at 50 MHz)
- REQ_CYCLES, 16: cycles data and clock are both held low before the clock is released
- TIMEOUT_CYCLES, 1000000: maximum clk cycles between device falling edges (20 ms)
- clk  in  1  system clock, 50 MHz (CLOCK_50)
- reset  in  1  asynchronous, active-high; one clock, all state returns to IDLE
- tx_valid  in  1  request to send tx_data
- tx_data  in  8  command byte
- tx_ready  out  1  high only in IDLE; transfer accepted on tx_valid & tx_ready
- ps2_clk_in  in  1  raw PS2_CLK pin level, asynchronous
- ps2_dat_in  in  1  raw PS2_DAT pin level, asynchronous
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_dat_oe  out  1  1 = pull PS2_DAT low
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a frame completes or aborts
- ack_ok  out  1  valid with done; 1 = device pulled data low in the ACK slot
- error  out  1  valid with done; 1 = timeout abort

## Operation
- Input conditioning:
  - each pin passes through a 2-flop synchronizer
  - a falling edge (`fall`) is registered synced-previous 1 and synced-current 0
- State machine:
  - IDLE: all outputs low except tx_ready. On accept, latch tx_data and parity = ~^tx_data (odd parity), then go to INHIBIT.
  - INHIBIT: clk_oe=1, dat_oe=0 for INHIBIT_CYCLES, then go to REQ.
  - REQ: clk_oe=1, dat_oe=1 (start bit) for REQ_CYCLES, then go to SEND with bit index 0.
  - SEND: clk_oe=0. On each `fall`, drive the next bit: dat_oe = ~bit.
    - indexes 0-7 send data LSB first
    - index 8 sends parity
    - index 9 sends stop: dat_oe=0
    - after index 9, go to ACK
  - ACK: on the next `fall`, sample synced data: ack_ok = ~dat. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clk and synced dat are both 1, then pulse done and go to IDLE.
- Timeout counter:
  - clears on entry to SEND and on every `fall`
  - in SEND, ACK or WAIT_IDLE, reaching TIMEOUT_CYCLES releases both enables, pulses done with error=1 and ack_ok=0, and goes to IDLE
- Edge cases:
  - tx_valid while busy is ignored, with no queueing
  - tx_data changing after accept has no effect
  - `fall` edges seen in IDLE, INHIBIT or REQ are ignored

## Timing
- Reset values: ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, ack_ok=0, error=0, tx_ready=1. Reset is asynchronous, so mid-frame reset releases both lines immediately, with no glitch-low.
- Accept at cycle 0 gives clk_oe=1 at cycle 1. clk_oe stays high for INHIBIT_CYCLES+REQ_CYCLES cycles. dat_oe rises at cycle 1+INHIBIT_CYCLES.
- Pin falling edge to `fall`: 3 clk cycles. `fall` to updated dat_oe: +1 cycle. Total 4 cycles (80 ns), well inside the device's clock-low half period.
- done lasts exactly 1 cycle. tx_ready returns the cycle after done. A back-to-back accept is possible the cycle after done.
- All outputs are registered, except tx_ready and busy, which are decoded from state.

## Structure
- Package ps2_pkg holds:
  - state enum: IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE
  - odd-parity function
  - constants CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, RESP_ACK=8'hFA, shared with the receiver side
- Sub-module ps2_line_sync: 2-flop synchronizer plus falling-edge detector. Instantiated twice, for clk and for dat; the dat edge output is unused.

## Test plan
- Send 0xED with a device model clocking at 12.5 kHz and ACKing:
  - dat sampled at device rising edges is 0,1,0,1,1,0,1,1,1,1,1
  - ACK slot low, then done=1, ack_ok=1, error=0
- Send 0x01 -> parity bit 0. Send 0xFF -> parity bit 1. Send 0x00 -> parity bit 1. Verify a frame check on each.
- Device leaves dat high in the ACK slot -> done=1, ack_ok=0, error=0.
- Device never clocks after REQ -> exactly TIMEOUT_CYCLES after SEND entry: done=1, error=1, both oe=0, tx_ready=1.
- Assert reset at bit index 4 with dat_oe=1 -> dat_oe and clk_oe are 0 in the same cycle, busy=0. A new 0xFF frame completes normally afterwards.
- Pulse tx_valid with 0x55 during INHIBIT of a 0xED frame -> ignored; only the 0xED bits appear on the line.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 types, command constants and parity helper
// Contents:
//   ps2_state_t  host transmitter states
//   odd_parity   parity bit that makes data+parity contain an odd number of ones
//   CMD_*/RESP_* command and response bytes shared with the receiver side
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-flop synchronizer with registered falling-edge detect
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   pin    in   raw asynchronous pin level
//   level  out  synchronized pin level
//   fall   out  one-cycle pulse, 3 clocks after the pin falls
module ps2_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic fall
);

  logic meta;
  logic prev;

  // Flops reset to 1 (idle bus level) so leaving reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
      fall  <= 1'b0;
    end else begin
      meta  <= pin;
      level <= meta;
      prev  <= level;
      fall  <= prev & ~level;
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
// Ports:
//   clk         in   system clock (CLOCK_50)
//   reset       in   asynchronous active-high reset
//   tx_valid    in   request to send tx_data
//   tx_data     in   command byte
//   tx_ready    out  high only in IDLE
//   ps2_clk_in  in   raw PS2_CLK level
//   ps2_dat_in  in   raw PS2_DAT level
//   ps2_clk_oe  out  1 = pull PS2_CLK low
//   ps2_dat_oe  out  1 = pull PS2_DAT low
//   busy        out  high in every state except IDLE
//   done        out  one-cycle pulse when a frame completes or aborts
//   ack_ok      out  valid with done, device acknowledged
//   error       out  valid with done, timeout abort
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int REQ_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int PW = $clog2(PHASE_MAX + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  ps2_state_t    state;
  logic [PW-1:0] phase_cnt;
  logic [TW-1:0] tout_cnt;
  logic [8:0]    shreg;      // {parity, data}, shifted out LSB first
  logic [3:0]    bit_idx;
  logic          ack_seen;

  logic clk_s, clk_fall;
  logic dat_s, dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (ps2_clk_in),
    .level (clk_s),
    .fall  (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk   (clk),
    .reset (reset),
    .pin   (ps2_dat_in),
    .level (dat_s),
    .fall  (dat_fall_unused)
  );

  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      phase_cnt  <= '0;
      tout_cnt   <= '0;
      shreg      <= '0;
      bit_idx    <= '0;
      ack_seen   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      done       <= 1'b0;
      ack_ok     <= 1'b0;
      error      <= 1'b0;
    end else begin
      done   <= 1'b0;
      ack_ok <= 1'b0;
      error  <= 1'b0;
      case (state)
        IDLE: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          if (tx_valid) begin
            shreg      <= {odd_parity(tx_data), tx_data};
            phase_cnt  <= '0;
            ps2_clk_oe <= 1'b1;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (phase_cnt == PW'(INHIBIT_CYCLES - 1)) begin
            phase_cnt  <= '0;
            ps2_dat_oe <= 1'b1;  // start bit
            state      <= REQ;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        REQ: begin
          if (phase_cnt == PW'(REQ_CYCLES - 1)) begin
            ps2_clk_oe <= 1'b0;
            bit_idx    <= '0;
            tout_cnt   <= '0;
            state      <= SEND;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        SEND, ACK, WAIT_IDLE: begin
          if (done) begin
            // done was pulsed last cycle; tx_ready follows one cycle later
            state <= IDLE;
          end else if (!clk_fall && tout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            ps2_clk_oe <= 1'b0;
            ps2_dat_oe <= 1'b0;
            done       <= 1'b1;
            error      <= 1'b1;
            state      <= WAIT_IDLE;
            ack_seen   <= 1'b0;
          end else begin
            tout_cnt <= clk_fall ? '0 : tout_cnt + 1'b1;
            case (state)
              SEND: begin
                if (clk_fall) begin
                  bit_idx <= bit_idx + 1'b1;
                  if (bit_idx == 4'd9) begin
                    ps2_dat_oe <= 1'b0;  // stop bit
                    state      <= ACK;
                  end else begin
                    ps2_dat_oe <= ~shreg[0];
                    shreg      <= {1'b0, shreg[8:1]};
                  end
                end
              end
              ACK: begin
                if (clk_fall) begin
                  ack_seen <= ~dat_s;
                  state    <= WAIT_IDLE;
                end
              end
              default: begin
                if (clk_s && dat_s) begin
                  done   <= 1'b1;
                  ack_ok <= ack_seen;
                end
              end
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - scoreboard bench with a PS/2 device model for ps2_host_tx
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 50;
  localparam int REQ = 16;
  localparam int TO  = 3000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, ps2_clk_oe, ps2_dat_oe, busy, done, ack_ok, error;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps2_clk_in, ps2_dat_in;

  // wired-AND open-drain bus
  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQ),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_dat_in (ps2_dat_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .busy       (busy),
    .done       (done),
    .ack_ok     (ack_ok),
    .error      (error)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic expire(input string name);
    n_checks++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  typedef struct packed {
    logic [10:0] bits;
    logic        ack;
    logic        err;
    logic        chk_bits;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [10:0] cap_bits;

  // Frame as seen on the wire, index 0 first: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d);
    int   ones;
    logic par;
    ones = $countones(d);
    par  = (ones % 2 == 0);
    return {1'b1, par, d, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1, expected no frame outstanding");
      end else begin
        mon_e = sb.pop_front();
        check("done_ack_ok", {31'b0, ack_ok}, {31'b0, mon_e.ack});
        check("done_error", {31'b0, error}, {31'b0, mon_e.err});
        check("done_oe_released", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        if (mon_e.chk_bits) check("frame_bits", {21'b0, cap_bits}, {21'b0, mon_e.bits});
      end
    end
  end

  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    while (!tx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) expire("send_ready");
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
  endtask

  // Returns at the first negedge after the host releases the clock line.
  task automatic wait_request(input logic spoof);
    int hi;
    int dat_at;
    hi = 0;
    dat_at = -1;
    while (ps2_clk_oe && hi < 10000) begin
      if (ps2_dat_oe && dat_at < 0) dat_at = hi;
      if (spoof && hi == 10) begin
        tx_valid = 1'b1;
        tx_data  = 8'h55;
      end
      @(negedge clk);
      if (spoof && hi == 10) tx_valid = 1'b0;
      hi++;
    end
    check("clk_oe_high_cycles", hi, INH + REQ);
    check("dat_oe_rise_cycle", dat_at, INH);
    cap_bits[0] = ps2_dat_in;
  endtask

  task automatic clock_bits(input int half, input int nbits);
    for (int k = 1; k <= nbits; k++) begin
      dev_clk = 1'b0;
      repeat (half) @(negedge clk);
      dev_clk = 1'b1;
      cap_bits[k] = ps2_dat_in;
      repeat (half) @(negedge clk);
    end
  endtask

  task automatic ack_slot(input int half, input logic do_ack);
    if (do_ack) dev_dat = 1'b0;
    repeat (half / 2) @(negedge clk);
    dev_clk = 1'b0;
    repeat (half) @(negedge clk);
    dev_clk = 1'b1;
    if (do_ack) begin
      repeat (half / 2) @(negedge clk);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!done) expire("wait_done");
    @(negedge clk);
    check("ready_after_done", {31'b0, tx_ready}, 32'd1);
  endtask

  task automatic do_frame(input logic [7:0] d, input int half, input logic do_ack, input logic spoof);
    sb.push_back('{bits: model_frame(d), ack: do_ack, err: 1'b0, chk_bits: 1'b1});
    send(d);
    wait_request(spoof);
    repeat (half) @(negedge clk);
    clock_bits(half, 10);
    ack_slot(half, do_ack);
    wait_done();
  endtask

  initial begin
    int n;
    #1000000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_tx_ready", {31'b0, tx_ready}, 32'd1);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_oe", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("rst_flags", {29'b0, done, ack_ok, error}, 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    do_frame(CMD_SET_LEDS, 40, 1'b1, 1'b0);
    do_frame(8'h01, 40, 1'b1, 1'b0);
    do_frame(CMD_RESET, 40, 1'b1, 1'b0);
    do_frame(8'h00, 40, 1'b1, 1'b0);
    do_frame(8'h3C, 40, 1'b0, 1'b0);

    // device never clocks
    sb.push_back('{bits: 11'd0, ack: 1'b0, err: 1'b1, chk_bits: 1'b0});
    send(8'hA5);
    wait_request(1'b0);
    n = 0;
    while (!done && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TO);
    @(negedge clk);
    check("timeout_ready_after", {31'b0, tx_ready}, 32'd1);

    // reset while bit index 4 (a 0 bit of 0xED) is being driven
    send(CMD_SET_LEDS);
    wait_request(1'b0);
    repeat (40) @(negedge clk);
    clock_bits(40, 4);
    dev_clk = 1'b0;
    repeat (10) @(negedge clk);
    check("bit4_dat_oe", {31'b0, ps2_dat_oe}, 32'd1);
    #3;
    reset = 1'b1;
    #1;
    check("reset_oe_release", {30'b0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    check("reset_busy", {31'b0, busy}, 32'd0);
    dev_clk = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    do_frame(CMD_RESET, 40, 1'b1, 1'b0);

    // tx_valid with 0x55 during INHIBIT must be ignored
    do_frame(CMD_SET_LEDS, 40, 1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      do_frame(8'($urandom), int'($urandom_range(20, 60)), ($urandom % 4) != 0, 1'b0);
    end

    repeat (50) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
